// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high), in_valid/in_ready with a, b, s in;
// out_valid/out_ready with y and zf/sf/cf/of out; busy while iterating.
`timescale 1ns/1ps
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             of,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;

  logic             accept;
  logic             iter_op;

  assign in_ready = ~rst & ((state_q == S_IDLE) |
                    ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign iter_op  = (s == OP_MUL) | (s == OP_DIVU) | (s == OP_REMU);

  // Single-cycle datapath
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_y;
  logic             sc_cf;
  logic             sc_of;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    sc_y  = '0;
    sc_cf = 1'b0;
    sc_of = 1'b0;
    unique case (s)
      OP_ADD: begin
        sc_y  = add_w[WIDTH-1:0];
        sc_cf = add_w[WIDTH];
        sc_of = (a[WIDTH-1] == b[WIDTH-1]) &
                (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y  = sub_w[WIDTH-1:0];
        sc_cf = sub_w[WIDTH];
        sc_of = (a[WIDTH-1] != b[WIDTH-1]) &
                (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_y = a & b;
      OP_OR:   sc_y = a | b;
      OP_XOR:  sc_y = a ^ b;
      OP_SLL:  sc_y = a << shamt;
      OP_SRL:  sc_y = a >> shamt;
      OP_SRA:  sc_y = $unsigned($signed(a) >>> shamt);
      OP_SLT:  sc_y = {{(WIDTH-1){1'b0}},
                       $signed(a) < $signed(b)};
      OP_SLTU: sc_y = {{(WIDTH-1){1'b0}}, a < b};
      default: sc_y = '0;
    endcase
  end

  // Iterative datapath.
  // MUL: {acc,mq} is the double-width product register; mq starts
  // as the multiplier and is consumed LSB first.
  // DIV: acc is the partial remainder, mq shifts the dividend out
  // and the quotient in.  With a zero divisor every step subtracts
  // nothing, giving an all-ones quotient and remainder == a.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH-1:0] mul_mq_n;
  logic [WIDTH:0]   div_r;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_n;
  logic [WIDTH-1:0] div_mq_n;
  logic             is_mul;
  logic [WIDTH-1:0] it_acc_n;
  logic [WIDTH-1:0] it_mq_n;
  logic [WIDTH-1:0] it_y;
  logic             it_of;

  assign mul_sum   = {1'b0, acc_q} +
                     (mq_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};

  assign div_r     = {acc_q, mq_q[WIDTH-1]};
  assign div_diff  = div_r - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_acc_n = div_ge ? div_diff[WIDTH-1:0]
                            : div_r[WIDTH-1:0];
  assign div_mq_n  = {mq_q[WIDTH-2:0], div_ge};

  assign is_mul    = (op_q == OP_MUL);
  assign it_acc_n  = is_mul ? mul_acc_n : div_acc_n;
  assign it_mq_n   = is_mul ? mul_mq_n : div_mq_n;
  assign it_y      = (op_q == OP_REMU) ? it_acc_n : it_mq_n;
  assign it_of     = is_mul & (|it_acc_n);

  // Control and next-state
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    y_d         = y_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    cf_d        = cf_q;
    of_d        = of_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    unique case (state_q)
      S_BUSY: begin
        acc_d = it_acc_n;
        mq_d  = it_mq_n;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          y_d         = it_y;
          zf_d        = ~|it_y;
          sf_d        = it_y[WIDTH-1];
          cf_d        = 1'b0;
          of_d        = it_of;
        end
      end
      default: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (iter_op) begin
            state_d     = S_BUSY;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            op_d        = s;
            opnd_d      = (s == OP_MUL) ? a : b;
            acc_d       = '0;
            mq_d        = (s == OP_MUL) ? b : a;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            y_d         = sc_y;
            zf_d        = ~|sc_y;
            sf_d        = sc_y[WIDTH-1];
            cf_d        = sc_cf;
            of_d        = sc_of;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= '0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      y_q         <= y_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      cf_q        <= cf_d;
      of_q        <= of_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign cf        = cf_q;
  assign of        = of_q;

endmodule
